constant_block_server: RTL and testbench
========================================

# constant_block_server

Block-serial server for the fixed Montgomery constants (k and N/N²) consumed by the reduction stage. It sits directly upstream of the reducer's `k_constant_block_in` / `modN_constant_block_in` ports, one instance per constant. The constant is loaded once as a stream of blocks into internal BRAM. It is then replayed LSB block first, advancing one block per `consumed_in` pulse and wrapping so that every reduction sees block 0 first. A prefetch FIFO hides BRAM read latency so the consumer can pull one block per cycle with no bubbles.

## Interface
Parameters:
- `REGISTER_SIZE`, 32, block width in bits.
- `NUM_BLOCKS`, 128, blocks per constant (4096 bits at default).
- `PREFETCH_DEPTH`, 4, prefetch FIFO entries; minimum 4.

Ports:
- `clk_in`  in  1  single clock; all logic on rising edge.
- `rst_in`  in  1  reset, synchronous, active-low.
- `load_valid_in`  in  1  one constant block present on `load_block_in`.
- `load_block_in`  in  REGISTER_SIZE  constant block; block 0 (LSB) first.
- `load_done_out`  out  1  one-cycle pulse on the cycle after the NUM_BLOCKS-th load beat.
- `consumed_in`  in  1  consumer took `block_out`; advance to the next block.
- `rewind_in`  in  1  restart replay at block 0.
- `ready_out`  out  1  `block_out` is valid.
- `block_out`  out  REGISTER_SIZE  current constant block (FIFO head).
- `block_index_out`  out  $clog2(NUM_BLOCKS)  index of `block_out`.
- `wrap_out`  out  1  high while `block_out` is block NUM_BLOCKS-1.
- `underflow_out`  out  1  sticky; set by `consumed_in` while `ready_out`=0.

## Operation
- States:
  - EMPTY: entered at reset; no constant loaded.
  - LOADING: write pointer active.
  - PRIMING: filling the FIFO.
  - READY: serving blocks.
- EMPTY→LOADING on `load_valid_in`. That beat is written to address 0.
- LOADING:
  - Each `load_valid_in` beat writes the next address.
  - Gaps between beats are allowed.
  - After beat NUM_BLOCKS-1: pulse `load_done_out`, clear the FIFO, zero the read pointer, go to PRIMING.
- PRIMING→READY when the FIFO holds PREFETCH_DEPTH entries.
- READY:
  - BRAM read latency is 2 cycles.
  - A read is issued each cycle that (FIFO count + reads in flight) < PREFETCH_DEPTH.
  - The read address increments modulo NUM_BLOCKS, so it wraps NUM_BLOCKS-1→0.
  - `consumed_in` pops the FIFO head. Pop and refill may occur in the same cycle.
- `rewind_in` in PRIMING or READY:
  - Flush the FIFO and discard in-flight reads.
  - Read pointer returns to 0; go to PRIMING.
  - Priority: rewind_in > consumed_in.
- `load_valid_in` in PRIMING or READY:
  - Aborts serving: FIFO flushed, `ready_out`←0.
  - Go to LOADING; that beat is written to address 0.
  - Priority: load_valid_in > rewind_in > consumed_in.
- `consumed_in` with `ready_out`=0: ignored except for setting `underflow_out`. Only reset clears `underflow_out`.
- `block_index_out` and `wrap_out` travel with each FIFO entry (index stored alongside data).
- Reset mid-load or mid-serve: the constant is lost and the state returns to EMPTY.

## Timing
- Reset values:
  - `ready_out`, `load_done_out`, `wrap_out`, `underflow_out` = 0.
  - `block_out` = 0, `block_index_out` = 0.
  - FIFO empty; write and read pointers = 0.
- Final load beat at cycle L:
  - `load_done_out` is high at L+1.
  - `ready_out` rises at L+6, with block 0 on `block_out`.
- `consumed_in` at cycle c (READY):
  - The next block is on `block_out` at c+1. Registered outputs, no combinational path from `consumed_in`.
- Sustained `consumed_in` every cycle from a full FIFO never drops `ready_out`. Throughput is 1 block/cycle, indefinitely, across wraps.
- `rewind_in` at cycle c: `ready_out`=0 from c+1 and rises at c+6 with block 0.
- `load_valid_in` while READY at cycle c: `ready_out`=0 from c+1.

## Test plan
- Load blocks 0x1000+i for i=0..127, then hold `consumed_in` low → `load_done_out` pulse at L+1; `ready_out` at L+6; `block_out`=0x1000, index 0.
- Pulse `consumed_in` every cycle for 300 cycles → `ready_out` never drops; `block_out` sequence 0x1000..0x107F repeating; `wrap_out` high on each 0x107F; index 0 follows 127.
- Irregular consumption (random 30% duty) over 500 pulses → `block_out` sequence identical to the in-order modulo-128 sequence; no duplicated or skipped blocks.
- Consume 50 blocks, then assert `rewind_in` together with `consumed_in` → `ready_out` low for 5 cycles; block 0x1000 presented; no advance from the simultaneous consume.
- Pulse `consumed_in` in EMPTY → `underflow_out`=1 and stays 1 through a subsequent load; cleared only by `rst_in`=0.
- Drive `rst_in`=0 for one cycle mid-load (beat 60), then restart the load with 0x2000+i → all outputs at reset values; after reload, first `block_out`=0x2000 and no 0x10xx value ever appears.

Source files
------------

// File: rtl/constant_block_server.sv
// constant_block_server: loads a Montgomery constant into BRAM, then replays it LSB block first through a prefetch FIFO.
// Ports:
//   clk_in, rst_in (sync, active-low)
//   load_valid_in/load_block_in : constant load stream, block 0 first; load_done_out pulses after the last beat
//   consumed_in                 : consumer took block_out; advance
//   rewind_in                   : restart replay at block 0
//   ready_out/block_out/block_index_out/wrap_out : FIFO head and its block index
//   underflow_out               : sticky, consumed_in seen while not ready
module constant_block_server #(
  parameter int REGISTER_SIZE  = 32,
  parameter int NUM_BLOCKS     = 128,
  parameter int PREFETCH_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          load_valid_in,
  input  logic [REGISTER_SIZE-1:0]      load_block_in,
  output logic                          load_done_out,
  input  logic                          consumed_in,
  input  logic                          rewind_in,
  output logic                          ready_out,
  output logic [REGISTER_SIZE-1:0]      block_out,
  output logic [$clog2(NUM_BLOCKS)-1:0] block_index_out,
  output logic                          wrap_out,
  output logic                          underflow_out
);
  localparam int AW = $clog2(NUM_BLOCKS);
  localparam int CW = $clog2(PREFETCH_DEPTH + 1);
  typedef enum logic [1:0] {EMPTY, LOADING, PRIMING, READY} state_t;
  state_t state, state_nx;
  logic [REGISTER_SIZE-1:0] mem [NUM_BLOCKS];
  logic [REGISTER_SIZE-1:0] fifo_data [PREFETCH_DEPTH];
  logic [REGISTER_SIZE-1:0] data_nx [PREFETCH_DEPTH];
  logic [AW-1:0] fifo_idx [PREFETCH_DEPTH];
  logic [AW-1:0] idx_nx [PREFETCH_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_addr, rd_nx, pend_idx;
  logic [CW-1:0] count, count_nx;
  logic [REGISTER_SIZE-1:0] pend_data;
  logic pend_v, serving, last_beat, flush, issue, pop, push;
  // A beat outside LOADING always restarts the load at address 0.
  assign serving   = state == PRIMING || state == READY;
  assign wr_addr   = state == LOADING ? wr_ptr : '0;
  assign last_beat = load_valid_in && wr_addr == AW'(NUM_BLOCKS - 1);
  assign flush     = (serving && (load_valid_in || rewind_in)) || last_beat;
  assign pop       = ready_out && consumed_in && !flush;
  assign push      = pend_v && !flush;
  assign issue     = serving && !flush && (count + CW'(pend_v)) < CW'(PREFETCH_DEPTH);
  assign rd_nx     = rd_ptr == AW'(NUM_BLOCKS - 1) ? '0 : rd_ptr + AW'(1);
  assign count_nx  = flush ? '0 : count + CW'(push) - CW'(pop);
  assign state_nx  = load_valid_in ? (last_beat ? PRIMING : LOADING) :
                     (serving && rewind_in) ? PRIMING :
                     (serving && count_nx == CW'(PREFETCH_DEPTH)) ? READY : state;
  // Shift-register FIFO: entry 0 is the head so the outputs come straight from flops.
  always_comb begin
    for (int i = 0; i < PREFETCH_DEPTH; i++) begin
      data_nx[i] = pop ? fifo_data[(i + 1) % PREFETCH_DEPTH] : fifo_data[i];
      idx_nx[i]  = pop ? fifo_idx[(i + 1) % PREFETCH_DEPTH] : fifo_idx[i];
      if (push && count - CW'(pop) == CW'(i)) begin
        data_nx[i] = pend_data;
        idx_nx[i]  = pend_idx;
      end
    end
  end
  // Constant store: synchronous read, result lands in the FIFO on the following edge.
  always_ff @(posedge clk_in) begin
    if (load_valid_in) mem[wr_addr] <= load_block_in;
    if (issue) pend_data <= mem[rd_ptr];
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state         <= EMPTY;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pend_v        <= 1'b0;
      pend_idx      <= '0;
      load_done_out <= 1'b0;
      underflow_out <= 1'b0;
      fifo_data     <= '{default: '0};
      fifo_idx      <= '{default: '0};
    end else begin
      state         <= state_nx;
      wr_ptr        <= load_valid_in ? wr_addr + AW'(1) : wr_ptr;
      rd_ptr        <= flush ? '0 : issue ? rd_nx : rd_ptr;
      count         <= count_nx;
      pend_v        <= issue;
      pend_idx      <= issue ? rd_ptr : pend_idx;
      load_done_out <= last_beat;
      underflow_out <= underflow_out | (consumed_in & ~ready_out);
      fifo_data     <= data_nx;
      fifo_idx      <= idx_nx;
    end
  end
  assign ready_out       = state == READY && count != '0;
  assign block_out       = fifo_data[0];
  assign block_index_out = fifo_idx[0];
  assign wrap_out        = ready_out && fifo_idx[0] == AW'(NUM_BLOCKS - 1);
endmodule

// File: tb/tb_constant_block_server.sv
// tb_constant_block_server: randomized self-checking bench against an array model of the loaded constant.
module tb_constant_block_server;
  localparam int W = 32;
  localparam int N = 128;
  localparam int D = 4;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic load_valid_in = 1'b0;
  logic [W-1:0] load_block_in = '0;
  logic consumed_in = 1'b0;
  logic rewind_in = 1'b0;
  logic load_done_out, ready_out, wrap_out, underflow_out;
  logic [W-1:0] block_out;
  logic [6:0] block_index_out;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] model [N];
  int exp_ptr = 0;

  constant_block_server #(.REGISTER_SIZE(W), .NUM_BLOCKS(N), .PREFETCH_DEPTH(D)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .load_valid_in(load_valid_in), .load_block_in(load_block_in), .load_done_out(load_done_out),
    .consumed_in(consumed_in), .rewind_in(rewind_in),
    .ready_out(ready_out), .block_out(block_out), .block_index_out(block_index_out),
    .wrap_out(wrap_out), .underflow_out(underflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic test_reset;
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_out); end
    checks++; if (load_done_out !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b expected 0", load_done_out); end
    checks++; if (wrap_out !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap_out); end
    checks++; if (underflow_out !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow_out); end
    checks++; if (block_out !== '0) begin errors++; $display("FAIL reset_block: got %h expected 0", block_out); end
    checks++; if (block_index_out !== '0) begin errors++; $display("FAIL reset_index: got %0d expected 0", block_index_out); end
    rst_in = 1'b1;
  endtask

  task automatic test_underflow;
    @(negedge clk_in);
    consumed_in = 1'b1;
    @(negedge clk_in);
    consumed_in = 1'b0;
    checks++; if (underflow_out !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", underflow_out); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL underflow_ready: got %b expected 0", ready_out); end
  endtask

  // Loads base+i into the constant, optionally with random gaps, then checks the done/ready timing.
  task automatic load_and_prime(input logic [W-1:0] base, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        @(negedge clk_in);
        load_valid_in = 1'b0;
      end
      @(negedge clk_in);
      checks++; if (load_done_out !== 1'b0) begin errors++; $display("FAIL load_done_early beat %0d: got %b expected 0", i, load_done_out); end
      if (i > 0) begin
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL ready_while_loading beat %0d: got %b expected 0", i, ready_out); end
      end
      load_valid_in = 1'b1;
      load_block_in = base + W'(i);
      model[i] = base + W'(i);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      load_valid_in = 1'b0;
      checks++; if (load_done_out !== (k == 1)) begin errors++; $display("FAIL load_done L+%0d: got %b expected %b", k, load_done_out, k == 1); end
      checks++; if (ready_out !== (k == 6)) begin errors++; $display("FAIL prime_ready L+%0d: got %b expected %b", k, ready_out, k == 6); end
    end
    checks++; if (block_out !== base) begin errors++; $display("FAIL first_block: got %h expected %h", block_out, base); end
    checks++; if (block_index_out !== 7'd0) begin errors++; $display("FAIL first_index: got %0d expected 0", block_index_out); end
    exp_ptr = 0;
  endtask

  task automatic test_load;
    load_and_prime(32'h1000, 1'b1);
    checks++; if (underflow_out !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b expected 1", underflow_out); end
  endtask

  // Consumes n blocks at the given duty cycle, checking every presented block against the model.
  task automatic test_stream(input int n, input int duty);
    int pulses = 0;
    int cyc = 0;
    while (pulses < n && cyc < 20000) begin
      @(negedge clk_in);
      cyc++;
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL stream_ready cyc %0d: got %b expected 1", cyc, ready_out); end
      checks++; if (block_out !== model[exp_ptr]) begin errors++; $display("FAIL stream_block cyc %0d: got %h expected %h", cyc, block_out, model[exp_ptr]); end
      checks++; if (block_index_out !== 7'(exp_ptr)) begin errors++; $display("FAIL stream_index cyc %0d: got %0d expected %0d", cyc, block_index_out, exp_ptr); end
      checks++; if (wrap_out !== (exp_ptr == N - 1)) begin errors++; $display("FAIL stream_wrap cyc %0d: got %b expected %b", cyc, wrap_out, exp_ptr == N - 1); end
      consumed_in = $urandom_range(99) < duty;
      if (consumed_in) begin
        pulses++;
        exp_ptr = (exp_ptr + 1) % N;
      end
    end
    checks++; if (pulses < n) begin errors++; $display("FAIL stream_budget: got %0d pulses expected %0d", pulses, n); end
    @(negedge clk_in);
    consumed_in = 1'b0;
  endtask

  task automatic test_rewind;
    test_stream(50, 100);
    @(negedge clk_in);
    rewind_in = 1'b1;
    consumed_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      rewind_in = 1'b0;
      consumed_in = 1'b0;
      checks++; if (ready_out !== (k == 6)) begin errors++; $display("FAIL rewind_ready c+%0d: got %b expected %b", k, ready_out, k == 6); end
    end
    checks++; if (block_out !== model[0]) begin errors++; $display("FAIL rewind_block: got %h expected %h", block_out, model[0]); end
    checks++; if (block_index_out !== 7'd0) begin errors++; $display("FAIL rewind_index: got %0d expected 0", block_index_out); end
    exp_ptr = 0;
  endtask

  task automatic test_reset_midload;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (i == 1) begin
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", ready_out); end
      end
      load_valid_in = 1'b1;
      load_block_in = 32'h1000 + W'(i);
    end
    @(negedge clk_in);
    load_valid_in = 1'b0;
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", ready_out); end
    checks++; if (load_done_out !== 1'b0) begin errors++; $display("FAIL midrst_load_done: got %b expected 0", load_done_out); end
    checks++; if (wrap_out !== 1'b0) begin errors++; $display("FAIL midrst_wrap: got %b expected 0", wrap_out); end
    checks++; if (underflow_out !== 1'b0) begin errors++; $display("FAIL midrst_underflow: got %b expected 0", underflow_out); end
    checks++; if (block_out !== '0) begin errors++; $display("FAIL midrst_block: got %h expected 0", block_out); end
    checks++; if (block_index_out !== '0) begin errors++; $display("FAIL midrst_index: got %0d expected 0", block_index_out); end
    load_and_prime(32'h2000, 1'b0);
    test_stream(200, 100);
  endtask

  initial begin
    test_reset;
    test_underflow;
    test_load;
    test_stream(300, 100);
    test_stream(500, 30);
    test_rewind;
    test_reset_midload;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
